// File: rtl/memory_access.sv
// memory_access: memory-access stage; registers EM_BUS and completes loads from the synchronous data SRAM.
// Optional macro MEM_RDATA_BUF_EN keeps first-cycle read data alive across writeback stalls.
module memory_access #(
  parameter int EM_BUS_WID = 195,
  parameter int MW_BUS_WID = 191,
  parameter int MD_FOR_WID = 116
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  EM_valid,
  input  logic [EM_BUS_WID-1:0] EM_BUS,
  output logic                  M_allowin,
  input  logic                  W_allowin,
  output logic                  MW_valid,
  output logic [MW_BUS_WID-1:0] MW_BUS,
  output logic [MD_FOR_WID-1:0] MD_for_BUS,
  input  logic                  ex_en,
  input  logic [31:0]           data_sram_rdata
);

  logic                  M_valid;
  logic                  M_ready_go;
  logic [EM_BUS_WID-1:0] EM_BUS_M;

  logic [31:0] pc;
  logic [31:0] em_rf_wdata;
  logic        gr_we;
  logic [4:0]  dest;
  logic [3:0]  res_from_mem;
  logic [31:0] vaddr;
  logic        ex;
  logic [7:0]  ecode;
  logic        esubcode;
  logic [13:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;

  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] rf_wdata_m;
  logic        gr_we_m;

  assign {pc, em_rf_wdata, gr_we, dest, res_from_mem, vaddr, ex, ecode, esubcode,
          csr_addr, csr_we, csr_wmask, csr_wdata} = EM_BUS_M;

  assign M_ready_go = 1'b1;
  assign M_allowin  = !M_valid || (M_ready_go && W_allowin);
  assign MW_valid   = M_valid && M_ready_go;

  // ex_en wins over a capture: the stage is flushed even if execute offers an instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      M_valid  <= 1'b0;
      EM_BUS_M <= '0;
    end else begin
      if (ex_en) begin
        M_valid <= 1'b0;
      end else if (M_allowin) begin
        M_valid <= EM_valid;
      end
      if (M_allowin && EM_valid) begin
        EM_BUS_M <= EM_BUS;
      end
    end
  end

`ifdef MEM_RDATA_BUF_EN
  logic        first_cycle;
  logic        hold_valid;
  logic [31:0] hold_data;

  // rdata is only guaranteed in the first M cycle; snapshot it if writeback stalls us then
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_cycle <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
    end else begin
      first_cycle <= M_allowin && EM_valid;
      if (ex_en || (MW_valid && W_allowin)) begin
        hold_valid <= 1'b0;
      end else if (first_cycle && M_valid && !W_allowin) begin
        hold_valid <= 1'b1;
        hold_data  <= data_sram_rdata;
      end
    end
  end

  assign ld_src = hold_valid ? hold_data : data_sram_rdata;
`else
  assign ld_src = data_sram_rdata;
`endif

  always_comb begin
    ld_byte = ld_src[7:0];
    case (vaddr[1:0])
      2'b00:   ld_byte = ld_src[7:0];
      2'b01:   ld_byte = ld_src[15:8];
      2'b10:   ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    ld_half = vaddr[1] ? ld_src[31:16] : ld_src[15:0];

    ld_data = ld_src;
    if (res_from_mem[3]) begin
      ld_data = ld_src;
    end else if (res_from_mem[1]) begin
      ld_data = {(res_from_mem[2] ? 16'h0000 : {16{ld_half[15]}}), ld_half};
    end else if (res_from_mem[0]) begin
      ld_data = {(res_from_mem[2] ? 24'h000000 : {24{ld_byte[7]}}), ld_byte};
    end

    rf_wdata_m = (|res_from_mem) ? ld_data : em_rf_wdata;
  end

  assign gr_we_m = gr_we && !ex;

  assign MW_BUS = {pc, rf_wdata_m, gr_we_m, dest, vaddr, ex, ecode, esubcode,
                   csr_addr, csr_we, csr_wmask, csr_wdata};

  assign MD_for_BUS = {dest & {5{M_valid && gr_we_m}}, rf_wdata_m, csr_we && M_valid,
                       csr_addr, csr_wmask, csr_wdata};

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized M-stage bench with a transaction-level scoreboard plus directed load/exception cases.
module tb_memory_access;

  logic         clk;
  logic         rstn;
  logic         EM_valid;
  logic [194:0] EM_BUS;
  logic         M_allowin;
  logic         W_allowin;
  logic         MW_valid;
  logic [190:0] MW_BUS;
  logic [115:0] MD_for_BUS;
  logic         ex_en;
  logic [31:0]  data_sram_rdata;

  memory_access dut (
    .clk             (clk),
    .rstn            (rstn),
    .EM_valid        (EM_valid),
    .EM_BUS          (EM_BUS),
    .M_allowin       (M_allowin),
    .W_allowin       (W_allowin),
    .MW_valid        (MW_valid),
    .MW_BUS          (MW_BUS),
    .MD_for_BUS      (MD_for_BUS),
    .ex_en           (ex_en),
    .data_sram_rdata (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rfw;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  rfm;
    logic [31:0] vaddr;
    logic        ex;
    logic [7:0]  ecode;
    logic        esub;
    logic [13:0] caddr;
    logic        cwe;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic        got;
    logic [31:0] rd;
  } ins_t;

  int checks = 0;
  int failures = 0;

  ins_t         q[$];
  logic [190:0] ret_bus;
  logic         ret_seen;
  logic [115:0] md_obs;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [194:0] em_pack(input ins_t e);
    return {e.pc, e.rfw, e.gr_we, e.dest, e.rfm, e.vaddr, e.ex, e.ecode, e.esub,
            e.caddr, e.cwe, e.wmask, e.wdata};
  endfunction

  // load result from the architectural rules, using plain shifts and modulo
  function automatic logic [31:0] exp_rfw(input ins_t e);
    int unsigned v;
    if (e.rfm == 4'b0000) return e.rfw;
    if (e.rfm[3]) return e.rd;
    if (e.rfm[1]) begin
      v = (e.rd >> (e.vaddr[1] ? 16 : 0)) % 65536;
      if (!e.rfm[2] && v >= 32768) v = v + 32'hFFFF0000;
      return v;
    end
    v = (e.rd >> (8 * e.vaddr[1:0])) % 256;
    if (!e.rfm[2] && v >= 128) v = v + 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic [190:0] mw_pack(input ins_t e);
    return {e.pc, exp_rfw(e), e.gr_we & ~e.ex, e.dest, e.vaddr, e.ex, e.ecode, e.esub,
            e.caddr, e.cwe, e.wmask, e.wdata};
  endfunction

  function automatic logic [115:0] md_pack(input ins_t e);
    return {e.dest & {5{e.gr_we & ~e.ex}}, exp_rfw(e), e.cwe, e.caddr, e.wmask, e.wdata};
  endfunction

  function automatic ins_t rand_ins();
    ins_t e;
    e.pc    = $urandom;
    e.rfw   = $urandom;
    e.gr_we = 1'($urandom_range(0, 1));
    e.dest  = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 5))
      0:       e.rfm = 4'b0000;
      1:       e.rfm = 4'b1000;
      2:       e.rfm = 4'b0001;
      3:       e.rfm = 4'b0101;
      4:       e.rfm = 4'b0010;
      default: e.rfm = 4'b0110;
    endcase
    e.vaddr = $urandom;
    e.ex    = ($urandom_range(0, 7) == 0);
    e.ecode = 8'($urandom_range(0, 255));
    e.esub  = 1'($urandom_range(0, 1));
    e.caddr = 14'($urandom_range(0, 16383));
    e.cwe   = 1'($urandom_range(0, 1));
    e.wmask = $urandom;
    e.wdata = $urandom;
    e.got   = 1'b0;
    e.rd    = '0;
    return e;
  endfunction

  // one clock: drive at negedge, check against the scoreboard, then update it
  task automatic cycle(input logic emv, input ins_t ni, input logic wa, input logic exe,
                       input logic [31:0] rd);
    logic         mv;
    logic [190:0] mwm;
    logic [115:0] mdm;
    ins_t         h;
    @(negedge clk);
    EM_valid        = emv;
    EM_BUS          = em_pack(ni);
    W_allowin       = wa;
    ex_en           = exe;
    data_sram_rdata = rd;
    #1;
    mv = (q.size() != 0);
    if (mv && !q[0].got) begin
      h     = q[0];
      h.got = 1'b1;
      h.rd  = rd;
      q[0]  = h;
    end
    chk("mw_valid", MW_valid, mv);
    chk("m_allowin", M_allowin, !mv || wa);
    md_obs = MD_for_BUS;
    if (mv) begin
      mwm = '1;
      mdm = '1;
      if (q[0].ex && q[0].rfm != 4'b0000) begin
        mwm[158:127] = '0;
        mdm[110:79]  = '0;
      end
      chk("md_bus", MD_for_BUS & mdm, md_pack(q[0]) & mdm);
      if (wa && !exe) begin
        chk("mw_bus", MW_BUS & mwm, mw_pack(q[0]) & mwm);
        ret_bus  = MW_BUS;
        ret_seen = 1'b1;
        void'(q.pop_front());
      end
    end else begin
      chk("md_idle", {MD_for_BUS[115:111], MD_for_BUS[78]}, 6'b0);
    end
    if (exe) q.delete();
    if (emv && (!mv || wa) && !exe) begin
      h     = ni;
      h.got = 1'b0;
      q.push_back(h);
    end
  endtask

  task automatic run_load(input string tag, input logic [3:0] rfm, input logic [31:0] va,
                          input logic [31:0] rd, input logic [31:0] exp);
    ins_t e;
    e       = rand_ins();
    e.rfm   = rfm;
    e.vaddr = va;
    e.ex    = 1'b0;
    e.gr_we = 1'b1;
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);
    ret_seen = 1'b0;
    cycle(1'b1, e, 1'b1, 1'b0, $urandom);
    cycle(1'b0, e, 1'b1, 1'b0, rd);
    chk({tag, "_ret"}, ret_seen, 1'b1);
    chk(tag, ret_bus[158:127], exp);
    chk({tag, "_mddest"}, md_obs[115:111], e.dest);
  endtask

  ins_t e;
  logic wa_r;
  logic exe_r;
  logic emv_r;

  initial begin
    rstn = 1'b0;
    EM_valid = 1'b0;
    EM_BUS = '0;
    W_allowin = 1'b1;
    ex_en = 1'b0;
    data_sram_rdata = 32'h0;
    ret_seen = 1'b0;
    ret_bus = '0;
    md_obs = '0;
    #3;
    chk("rst_mw_valid", MW_valid, 1'b0);
    chk("rst_mw_bus", MW_BUS, 191'b0);
    chk("rst_md_dest", MD_for_BUS[115:111], 5'b0);
    chk("rst_md_csr_we", MD_for_BUS[78], 1'b0);
    chk("rst_allowin", M_allowin, 1'b1);
    @(negedge clk);
    rstn = 1'b1;

    run_load("ld_w", 4'b1000, 32'h0000_1000, 32'h8899AABB, 32'h8899AABB);
    run_load("ld_b", 4'b0001, 32'h0000_2003, 32'h80112233, 32'hFFFFFF80);
    run_load("ld_bu", 4'b0101, 32'h0000_2003, 32'h80112233, 32'h00000080);
    run_load("ld_h", 4'b0010, 32'h0000_3002, 32'h80017FFF, 32'hFFFF8001);
    run_load("ld_hu", 4'b0110, 32'h0000_3002, 32'h80017FFF, 32'h00008001);
    run_load("ld_b0", 4'b0001, 32'h0000_2000, 32'h80112233, 32'h00000033);
    run_load("ld_h0", 4'b0010, 32'h0000_3000, 32'h80017FFF, 32'h00007FFF);

    // flush on the capture edge
    e = rand_ins();
    e.gr_we = 1'b1;
    e.ex = 1'b0;
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);
    ret_seen = 1'b0;
    cycle(1'b1, e, 1'b1, 1'b1, 32'h0);
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);
    chk("exen_ret", ret_seen, 1'b0);
    chk("exen_mddest", md_obs[115:111], 5'b0);

    // execute-raised exception passes through with gr_we squashed
    e = rand_ins();
    e.gr_we = 1'b1;
    e.ex = 1'b1;
    e.ecode = 8'h09;
    e.rfm = 4'b1000;
    ret_seen = 1'b0;
    cycle(1'b1, e, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);
    chk("ex_ret", ret_seen, 1'b1);
    chk("ex_flag", ret_bus[88], 1'b1);
    chk("ex_ecode", ret_bus[87:80], 8'h09);
    chk("ex_gr_we", ret_bus[126], 1'b0);
    chk("ex_mddest", md_obs[115:111], 5'b0);

`ifdef MEM_RDATA_BUF_EN
    e = rand_ins();
    e.rfm = 4'b1000;
    e.ex = 1'b0;
    ret_seen = 1'b0;
    cycle(1'b1, e, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, e, 1'b0, 1'b0, 32'h12345678);
    cycle(1'b0, e, 1'b0, 1'b0, 32'hDEADBEEF);
    cycle(1'b0, e, 1'b0, 1'b0, 32'hDEADBEEF);
    chk("hold_noret", ret_seen, 1'b0);
    cycle(1'b0, e, 1'b1, 1'b0, 32'hDEADBEEF);
    chk("hold_ret", ret_seen, 1'b1);
    chk("hold_data", ret_bus[158:127], 32'h12345678);
`endif

    // reset in the middle of a load discards it
    e = rand_ins();
    e.rfm = 4'b1000;
    e.ex = 1'b0;
    e.gr_we = 1'b1;
    cycle(1'b1, e, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    EM_valid = 1'b0;
    data_sram_rdata = 32'hCAFEF00D;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_mw_valid", MW_valid, 1'b0);
    chk("mid_rst_mw_bus", MW_BUS, 191'b0);
    chk("mid_rst_md_dest", MD_for_BUS[115:111], 5'b0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, e, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 600; i++) begin
      e     = rand_ins();
      wa_r  = ($urandom_range(0, 3) != 0);
      exe_r = ($urandom_range(0, 19) == 0);
      emv_r = 1'($urandom_range(0, 1));
`ifndef MEM_RDATA_BUF_EN
      if (q.size() != 0 && !q[0].got && q[0].rfm != 4'b0000) wa_r = 1'b1;
`endif
      cycle(emv_r, e, wa_r, exe_r, $urandom);
    end
    for (int i = 0; i < 3; i++) begin
      e = rand_ins();
      cycle(1'b0, e, 1'b1, 1'b0, $urandom);
    end
    chk("drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
